ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
- PS/2 keyboard receive stage; sits directly downstream of hps_io's PS/2 keyboard clock/data outputs.
- Synchronises and deglitches the two lines, then deframes 11-bit PS/2 frames.
- Checks odd parity and the stop bit, and buffers good scan-code bytes in a first-word-fall-through FIFO for the selected microcomputer's keyboard interface.
- Reports parity, framing and overflow errors as one-cycle pulses.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples required before a filtered line changes.
- FIFO_DEPTH, 16: byte FIFO depth; must be a power of 2, minimum 2.
- TIMEOUT_CYCLES, 50000: idle clk cycles mid-frame before the frame is abandoned (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock (clk_sys domain).
- N_RESET  in  1  reset; synchronous, active-low.
- ps2Clk  in  1  PS/2 clock, asynchronous, idle high.
- ps2Data  in  1  PS/2 data, asynchronous, idle high.
- rd_en  in  1  pop request; honoured only when valid=1.
- dout  out  8  FIFO head byte; valid when valid=1.
- valid  out  1  FIFO not empty.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  number of bytes held.
- parity_err  out  1  one-cycle pulse: a frame was dropped for bad parity.
- frame_err  out  1  one-cycle pulse: a frame was dropped for a bad stop bit or a timeout.
- overflow  out  1  one-cycle pulse: a good byte was dropped because the FIFO was full.

Behaviour:
- Reset (N_RESET=0 at a clk edge):
  - FSM goes to IDLE; bit counter, shift register and timeout counter clear.
  - Synchronisers and filtered lines preset to 1.
  - FIFO empties: valid=0, fifo_count=0, dout=0.
  - All error pulses are 0.
  - Reset mid-frame discards the partial frame with no error pulse.
- Input conditioning:
  - Each line passes through a 2-FF synchroniser.
  - A filtered line takes the synchronised value only after FILTER_LEN consecutive equal samples that differ from its current value.
  - Glitches shorter than FILTER_LEN cycles are ignored.
  - fall = filtered ps2Clk goes 1 to 0 (single-cycle strobe). Data is sampled from filtered ps2Data in the fall cycle.
- FSM (states IDLE, DATA, PARITY, STOP), acting on fall:
  - IDLE: data=0 (start bit) moves to DATA with bitcnt=0. data=1 stays in IDLE with no error.
  - DATA: shift in LSB-first; after the 8th bit (bitcnt=7) move to PARITY.
  - PARITY: store the bit; move to STOP.
  - STOP: return to IDLE unconditionally, then classify the frame:
    - XOR of the 8 data bits and the parity bit is 0 → parity_err pulse, no push.
    - Otherwise, stop bit is 0 → frame_err pulse, no push.
    - Otherwise → push the byte.
    - If both parity and stop are bad, only parity_err pulses.
  - Error pulses and the push occur in the cycle after the STOP fall.
- Timeout:
  - In any state except IDLE, the counter increments each cycle and clears on fall.
  - When it reaches TIMEOUT_CYCLES-1: FSM goes to IDLE and frame_err pulses next cycle.
- FIFO (first-word fall-through):
  - valid and dout update the cycle after a push into an empty FIFO.
  - Latency from a push to valid: 1 cycle.
  - rd_en with valid=1 pops, and the next entry appears the next cycle. rd_en with valid=0 is ignored.
  - Push when full and no pop: byte dropped, overflow pulses, contents unchanged.
  - Push and pop in the same cycle: both occur, fifo_count unchanged, no overflow (including when full).
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count saturates within 0..FIFO_DEPTH by construction.

Decomposition:
- Package ps2_pkg holds:
  - enum rx_state_t {IDLE, DATA, PARITY, STOP};
  - constants PS2_DATA_BITS=8 and PS2_FRAME_BITS=11.
- One sub-module, ps2_byte_fifo (DEPTH parameter, push/pop/full/empty/count, first-word fall-through), instantiated once.
- Synchroniser, filter and FSM stay in ps2_kbd_rx.

Test Plan:
- Good frame: start 0, data 0x1C, parity 0, stop 1, at 12.5 kHz PS/2 clock → valid=1, dout=0x1C, fifo_count=1, no error pulses. rd_en for 1 cycle → valid=0.
- Bad parity: 0x1C sent with parity 1 → parity_err one pulse, fifo_count=0. Next frame 0xF0 (parity 1) → dout=0xF0.
- Bad stop and glitch: 0x5A sent with stop 0 → frame_err one pulse, no push. A 3-cycle low glitch on ps2Clk during IDLE → no state change, no error.
- Timeout: 4 data bits sent, then the clock stays high for 50000 cycles → frame_err one pulse, FSM back in IDLE. Following 0x29 frame → received correctly.
- Overflow and simultaneity:
  - 17 frames 0x01..0x11 with no reads → fifo_count=16, overflow one pulse on the 17th, dout=0x01.
  - Then rd_en held during a push completion → count stays 16, no overflow.
- Reset mid-frame: N_RESET low after 5 data bits → all outputs zero/idle, no pulses. A complete 0x76 frame after release → dout=0x76.

Source files
------------

// File: rtl/ps2_kbd_rx_pkg.sv
// Shared types and frame constants for the PS/2 keyboard receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_kbd_rx_byte_fifo.sv
// First-word fall-through byte FIFO; the head is held in a register so the
// storage array is only ever read through a registered port.
module ps2_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_inc;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             do_push;
    logic             do_pop;

    assign empty      = (count_reg == '0);
    assign full       = (count_reg == CW'(DEPTH));
    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            dout_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // Head register: the next stored entry if one exists, else the incoming byte.
            if (do_pop) begin
                if (count_reg > CW'(1)) begin
                    dout_reg <= mem[rd_ptr_inc];
                end else if (do_push) begin
                    dout_reg <= din;
                end
            end else if (do_push && empty) begin
                dout_reg <= din;
            end
        end
    end

    assign dout  = dout_reg;
    assign count = count_reg;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: line conditioning, 11-bit frame deframing with
// parity/stop/timeout checks, and a byte FIFO for the keyboard consumer.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                              clk,
    input  logic                              N_RESET,
    input  logic                              ps2Clk,
    input  logic                              ps2Data,
    input  logic                              rd_en,
    output logic [7:0]                        dout,
    output logic                              valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              parity_err,
    output logic                              frame_err,
    output logic                              overflow
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int BW = $clog2(PS2_DATA_BITS);

    logic [1:0] line_raw;
    logic [1:0] line_filt;

    assign line_raw = {ps2Data, ps2Clk};

    // Index 0 is the PS/2 clock, index 1 the PS/2 data line.
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
        logic          sync1_reg;
        logic          sync2_reg;
        logic          filt_reg;
        logic [FW-1:0] cnt_reg;

        always_ff @(posedge clk) begin
            if (!N_RESET) begin
                sync1_reg <= 1'b1;
                sync2_reg <= 1'b1;
                filt_reg  <= 1'b1;
                cnt_reg   <= '0;
            end else begin
                sync1_reg <= line_raw[gi];
                sync2_reg <= sync1_reg;
                if (sync2_reg == filt_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == FW'(FILTER_LEN - 1)) begin
                    filt_reg <= sync2_reg;
                    cnt_reg  <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end

        assign line_filt[gi] = filt_reg;
    end

    logic clk_filt_d_reg;
    logic fall;
    logic data_bit;

    assign fall     = clk_filt_d_reg && !line_filt[0];
    assign data_bit = line_filt[1];

    rx_state_t                state_reg, state_next;
    logic [BW-1:0]            bitcnt_reg, bitcnt_next;
    logic [PS2_DATA_BITS-1:0] shift_reg, shift_next;
    logic                     parity_reg, parity_next;
    logic [TW-1:0]            tmo_reg, tmo_next;
    logic                     parity_err_reg, parity_err_next;
    logic                     frame_err_reg, frame_err_next;
    logic                     push_reg, push_next;
    logic                     overflow_reg;
    logic                     fifo_full;
    logic                     fifo_empty;

    always_ff @(posedge clk) begin
        if (!N_RESET) begin
            clk_filt_d_reg <= 1'b1;
            state_reg      <= IDLE;
            bitcnt_reg     <= '0;
            shift_reg      <= '0;
            parity_reg     <= 1'b0;
            tmo_reg        <= '0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            push_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            clk_filt_d_reg <= line_filt[0];
            state_reg      <= state_next;
            bitcnt_reg     <= bitcnt_next;
            shift_reg      <= shift_next;
            parity_reg     <= parity_next;
            tmo_reg        <= tmo_next;
            parity_err_reg <= parity_err_next;
            frame_err_reg  <= frame_err_next;
            push_reg       <= push_next;
            overflow_reg   <= push_reg && fifo_full && !(rd_en && !fifo_empty);
        end
    end

    always_comb begin
        state_next      = state_reg;
        bitcnt_next     = bitcnt_reg;
        shift_next      = shift_reg;
        parity_next     = parity_reg;
        tmo_next        = '0;
        parity_err_next = 1'b0;
        frame_err_next  = 1'b0;
        push_next       = 1'b0;

        if (state_reg != IDLE && !fall) begin
            tmo_next = tmo_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (fall && !data_bit) begin
                    state_next  = DATA;
                    bitcnt_next = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_next  = {data_bit, shift_reg[PS2_DATA_BITS-1:1]};
                    bitcnt_next = bitcnt_reg + 1'b1;
                    if (bitcnt_reg == BW'(PS2_DATA_BITS - 1)) begin
                        state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    parity_next = data_bit;
                    state_next  = STOP;
                end
            end
            STOP: begin
                // Parity is checked before the stop bit, so a doubly bad frame reports parity only.
                if (fall) begin
                    state_next = IDLE;
                    if (!(^{shift_reg, parity_reg})) begin
                        parity_err_next = 1'b1;
                    end else if (!data_bit) begin
                        frame_err_next = 1'b1;
                    end else begin
                        push_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_reg != IDLE && !fall && tmo_reg == TW'(TIMEOUT_CYCLES - 1)) begin
            state_next     = IDLE;
            frame_err_next = 1'b1;
            tmo_next       = '0;
        end
    end

    // The shift register is untouched in IDLE, so it still holds the byte during the push cycle.
    ps2_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PS2_DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (N_RESET),
        .push  (push_reg),
        .din   (shift_reg),
        .pop   (rd_en),
        .dout  (dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign valid      = !fifo_empty;
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: frames are generated at the PS/2 bit level,
// expected bytes and error events are queued, and monitors compare DUT output.
module tb_ps2_kbd_rx;

    localparam int FILTER_LEN = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int TIMEOUT    = 1000;
    localparam int HALF       = 25;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);

    logic          clk = 1'b0;
    logic          N_RESET = 1'b0;
    logic          ps2Clk = 1'b1;
    logic          ps2Data = 1'b1;
    logic          rd_auto = 1'b0;
    logic          rd_man = 1'b0;
    logic          rd_en;
    logic [7:0]    dout;
    logic          valid;
    logic [CW-1:0] fifo_count;
    logic          parity_err;
    logic          frame_err;
    logic          overflow;

    assign rd_en = rd_auto | rd_man;

    ps2_kbd_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk        (clk),
        .N_RESET    (N_RESET),
        .ps2Clk     (ps2Clk),
        .ps2Data    (ps2Data),
        .rd_en      (rd_en),
        .dout       (dout),
        .valid      (valid),
        .fifo_count (fifo_count),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_bytes[$];
    int         exp_evt[$];
    int         model_count = 0;
    bit         auto_on = 0;
    int         lat = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference model: classify a frame from its bits and queue what should follow.
    task automatic predict(input logic [7:0] d, input bit par_good, input bit stop_good);
        if (!par_good) exp_evt.push_back(1);
        else if (!stop_good) exp_evt.push_back(2);
        else if (model_count == FIFO_DEPTH) exp_evt.push_back(3);
        else begin
            exp_bytes.push_back(d);
            model_count++;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_good, input bit stop_good,
                              input int nbits, input bit pop_at_push, input bit measure);
        logic [10:0] bits;
        bits[0]   = 1'b0;
        bits[8:1] = d;
        bits[9]   = par_good ? ~(^d) : (^d);
        bits[10]  = stop_good;
        for (int i = 0; i < nbits; i++) begin
            ps2Data = bits[i];
            repeat (HALF) step();
            ps2Clk = 1'b0;
            for (int k = 1; k <= HALF; k++) begin
                step();
                rd_man = pop_at_push && (i == 10) && (k == lat - 1);
                if (measure && i == 10 && lat == 0 && valid) lat = k;
            end
            ps2Clk = 1'b1;
        end
        ps2Data = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (exp_bytes.size() != 0 || valid); i++) step();
        check("drain_pending", exp_bytes.size(), 0);
    endtask

    // Byte monitor: pops the FIFO whenever reading is enabled and compares the head.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_on && valid && N_RESET) begin
                if (exp_bytes.size() == 0) begin
                    check("unexpected_byte", int'(dout), -1);
                end else begin
                    check("rx_byte", int'(dout), int'(exp_bytes.pop_front()));
                    model_count--;
                end
                rd_auto = 1'b1;
            end else begin
                rd_auto = 1'b0;
            end
        end
    end

    // Event monitor: each pulse must match the next queued event (1 parity, 2 frame, 3 overflow).
    task automatic take_evt(input int kind);
        if (exp_evt.size() == 0) check("unexpected_pulse", kind, 0);
        else check("error_pulse_kind", kind, exp_evt.pop_front());
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (parity_err) take_evt(1);
            if (frame_err) take_evt(2);
            if (overflow) take_evt(3);
        end
    end

    initial begin
        #1_800_000;
        $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        bit pg, sg;

        repeat (5) step();
        check("reset_valid", valid, 0);
        check("reset_count", fifo_count, 0);
        check("reset_dout", dout, 0);
        check("reset_pulses", {parity_err, frame_err, overflow}, 0);
        N_RESET = 1'b1;
        repeat (5) step();

        // Good frame, read manually.
        predict(8'h1C, 1, 1);
        send_frame(8'h1C, 1, 1, 11, 0, 1);
        check("good_valid", valid, 1);
        check("good_dout", dout, 8'h1C);
        check("good_count", fifo_count, 1);
        check("latency_seen", int'(lat >= 2 && lat < HALF), 1);
        rd_man = 1'b1;
        step();
        rd_man = 1'b0;
        void'(exp_bytes.pop_front());
        model_count--;
        step();
        check("pop_valid", valid, 0);
        check("pop_count", fifo_count, 0);

        auto_on = 1;
        predict(8'h1C, 0, 1);
        send_frame(8'h1C, 0, 1, 11, 0, 0);
        repeat (20) step();
        check("badpar_count", fifo_count, 0);
        predict(8'hF0, 1, 1);
        send_frame(8'hF0, 1, 1, 11, 0, 0);
        repeat (20) step();

        predict(8'h5A, 1, 0);
        send_frame(8'h5A, 1, 0, 11, 0, 0);
        repeat (20) step();
        check("badstop_count", fifo_count, 0);
        ps2Clk = 1'b0;
        repeat (3) step();
        ps2Clk = 1'b1;
        repeat (40) step();

        // Timeout after four data bits.
        exp_evt.push_back(2);
        send_frame(8'h0F, 1, 1, 5, 0, 0);
        repeat (TIMEOUT + 50) step();
        check("timeout_pending", exp_evt.size(), 0);
        predict(8'h29, 1, 1);
        send_frame(8'h29, 1, 1, 11, 0, 0);
        drain();

        // Overflow: 17 frames with no reads.
        auto_on = 0;
        repeat (5) step();
        for (int i = 1; i <= 17; i++) begin
            predict(8'(i), 1, 1);
            send_frame(8'(i), 1, 1, 11, 0, 0);
            repeat (10) step();
        end
        check("full_count", fifo_count, FIFO_DEPTH);
        check("full_dout", dout, 8'h01);
        check("full_valid", valid, 1);
        check("overflow_pending", exp_evt.size(), 0);

        // Pop in the same cycle the next byte is pushed into the full FIFO.
        check("full_head_model", int'(dout), int'(exp_bytes.pop_front()));
        exp_bytes.push_back(8'h12);
        send_frame(8'h12, 1, 1, 11, 1, 0);
        repeat (5) step();
        check("simul_count", fifo_count, FIFO_DEPTH);
        check("simul_dout", dout, 8'h02);
        auto_on = 1;
        drain();

        // Reset in the middle of a frame.
        send_frame(8'h33, 1, 1, 6, 0, 0);
        repeat (3) step();
        N_RESET = 1'b0;
        repeat (5) step();
        check("midrst_valid", valid, 0);
        check("midrst_count", fifo_count, 0);
        check("midrst_dout", dout, 0);
        N_RESET = 1'b1;
        repeat (5) step();
        check("midrst_pulses", {parity_err, frame_err, overflow}, 0);
        predict(8'h76, 1, 1);
        send_frame(8'h76, 1, 1, 11, 0, 0);
        drain();

        // Randomised frames with occasional short clock glitches while idle.
        for (int n = 0; n < 20; n++) begin
            d  = 8'($urandom);
            pg = ($urandom_range(0, 3) != 0);
            sg = ($urandom_range(0, 3) != 0);
            predict(d, pg, sg);
            send_frame(d, pg, sg, 11, 0, 0);
            repeat (15) step();
            if ($urandom_range(0, 1) == 1) begin
                ps2Clk = 1'b0;
                repeat ($urandom_range(1, 5)) step();
                ps2Clk = 1'b1;
            end
            repeat ($urandom_range(20, 60)) step();
        end
        drain();
        repeat (50) step();
        check("final_evt_pending", exp_evt.size(), 0);
        check("final_count", fifo_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
